// File: rtl/clock_divider_pkg.sv
// Shared types for the clock divider controller: FSM state encoding and default width.
package clock_divider_pkg;

   localparam int DIV_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PENDING = 2'd2
   } state_e;

endpackage

// File: rtl/clock_divider_ctrl_mod_n_counter.sv
// Modulo-N period counter: counts 0..N-1, flags the last count, and takes a new modulus on load.
module mod_n_counter
   import clock_divider_pkg::*;
#(
   parameter int W = DIV_W_DEFAULT
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] mod_i,
   output logic [W-1:0] cnt_o,
   output logic [W-1:0] mod_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] mod_q, mod_d;

   assign wrap_o = (cnt_q == mod_q - W'(1));
   assign cnt_o  = cnt_q;
   assign mod_o  = mod_q;

   // Load restarts the period at 0, so a load at the wrap edge is seamless.
   always_comb begin
      cnt_d = cnt_q;
      mod_d = mod_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = '0;
         mod_d = mod_i;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         mod_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         mod_q <= mod_d;
      end
   end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Glitch-free programmable clock divider; divisor changes take effect only at period boundaries.
// Optional CLOCK_DIVIDER_CTRL_GATE_EN adds run_i to park the output low between periods.
module clock_divider_ctrl
   import clock_divider_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEFAULT
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             cfg_valid_i,
   input  logic [DIV_W-1:0] cfg_div_i,
`ifdef CLOCK_DIVIDER_CTRL_GATE_EN
   input  logic             run_i,
`endif
   output logic             cfg_ready_o,
   output logic             clk_o,
   output logic             tick_o,
   output logic             busy_o,
   output logic             err_o
);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic             clk_q, clk_d;
   logic             err_q, err_d;
   logic             gated;

   logic             accept, div_ill, div_legal, busy, wrap, boundary;
   logic             ctr_clr, ctr_load, ctr_en, cnt_wrap;
   logic [DIV_W-1:0] ctr_mod, cnt, mod;
   logic             apply;
   logic [DIV_W-1:0] apply_val;

   assign accept    = cfg_valid_i && cfg_ready_o;
   assign div_ill   = (cfg_div_i == DIV_W'(1));
   assign div_legal = (cfg_div_i >= DIV_W'(2));
   assign busy      = (state_q != IDLE);
   assign wrap      = busy && !gated && cnt_wrap;
   // A parked divider sits at a period boundary, so requests apply at once.
   assign boundary  = wrap || gated;

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      ctr_clr   = 1'b0;
      ctr_load  = 1'b0;
      ctr_mod   = cfg_div_i;
      apply     = 1'b0;
      apply_val = cfg_div_i;
      case (state_q)
         IDLE: begin
            if (accept && div_legal) begin
               ctr_load = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (accept && !div_ill) begin
               if (boundary) begin
                  apply = 1'b1;
               end else begin
                  pend_d  = cfg_div_i;
                  state_d = PENDING;
               end
            end
         end
         PENDING: begin
            if (wrap) begin
               apply     = 1'b1;
               apply_val = pend_q;
            end
         end
         default: state_d = IDLE;
      endcase
      if (apply) begin
         if (apply_val == '0) begin
            state_d = IDLE;
            ctr_clr = 1'b1;
         end else begin
            state_d  = RUN;
            ctr_load = 1'b1;
            ctr_mod  = apply_val;
         end
      end
      ctr_en = busy && !gated;
      // High for the first ceil(N/2) counts, delayed one cycle through clk_q.
      clk_d  = busy && !gated && (cnt < mod - (mod >> 1));
      err_d  = accept && div_ill;
   end

`ifdef CLOCK_DIVIDER_CTRL_GATE_EN
   logic gated_q, gated_d;

   assign gated   = gated_q;
   assign gated_d = (state_q == RUN) && (state_d == RUN) && (gated_q || wrap) && !run_i;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) gated_q <= 1'b0;
      else           gated_q <= gated_d;
   end
`else
   assign gated = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         pend_q  <= '0;
         clk_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
         err_q   <= err_d;
      end
   end

   mod_n_counter #(.W(DIV_W)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (reset_ni),
      .clr_i  (ctr_clr),
      .load_i (ctr_load),
      .en_i   (ctr_en),
      .mod_i  (ctr_mod),
      .cnt_o  (cnt),
      .mod_o  (mod),
      .wrap_o (cnt_wrap)
   );

   assign cfg_ready_o = (state_q != PENDING);
   assign busy_o      = busy;
   assign tick_o      = wrap;
   assign clk_o       = clk_q;
   assign err_o       = err_q;

endmodule
